piso_sr: RTL and testbench

//  Parallel-in serial-out shift register with load handshake and bit counter.

---
 rtl/sr_pkg.sv | 12 +
 rtl/piso_sr_if.sv | 37 +++
 rtl/sr_bit_counter.sv | 32 +++
 rtl/piso_sr.sv | 102 ++++++++++
 tb/tb_piso_sr.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the piso_sr / sipo_sr serial link.
// State encodings and default word width.
package sr_pkg;

    localparam int SR_WIDTH = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } sr_state_e;

endpackage

// File: rtl/piso_sr_if.sv
// Load/serial handshake bundle for piso_sr.
// master = word source and serial sink, slave = piso_sr.
interface piso_sr_if
    import sr_pkg::*;
#(
    parameter int WIDTH = SR_WIDTH
);

    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             data_out;
    logic             out_valid;
    logic             done;

    modport master (
        output data_in,
        output load_valid,
        input  load_ready,
        output shift_en,
        input  data_out,
        input  out_valid,
        input  done
    );

    modport slave (
        input  data_in,
        input  load_valid,
        output load_ready,
        input  shift_en,
        output data_out,
        output out_valid,
        output done
    );

endinterface

// File: rtl/sr_bit_counter.sv
// Loadable down-counter tracking bits left in a word.
// Loads WIDTH-1, decrements to zero, never wraps.
module sr_bit_counter
    import sr_pkg::*;
#(
    parameter int WIDTH = SR_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] r_cnt;

    // Count register: reload on a new word, step down per consumed bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CW'(WIDTH - 1);
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/piso_sr.sv
// Parallel-in serial-out shift register, transmit end of the link.
// Zero-bubble reload when a word arrives on the last-bit cycle.
module piso_sr
    import sr_pkg::*;
#(
    parameter int WIDTH     = SR_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    piso_sr_if.slave   bus
);

    sr_state_e        r_state;
    sr_state_e        w_next;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shifted;
    logic             r_done;
    logic             w_zero;
    logic             w_in_shift;
    logic             w_last;
    logic             w_step;
    logic             w_ready;
    logic             w_accept;
    logic             w_bit;

    assign w_in_shift = (r_state == ST_SHIFT);
    assign w_last     = w_in_shift & bus.shift_en & w_zero;
    assign w_step     = w_in_shift & bus.shift_en & ~w_zero;
    assign w_ready    = ~w_in_shift | w_last;
    assign w_accept   = w_ready & bus.load_valid;
    assign w_bit      = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];

    sr_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (reset),
        .i_load (w_accept),
        .i_dec  (w_step),
        .o_zero (w_zero)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: leave SHIFT only when the last bit goes with no reload
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.load_valid) w_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_last && !bus.load_valid) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Move the word one place toward the output end, zero fill
    always_comb begin
        w_shifted = '0;
        if (MSB_FIRST) begin
            w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
        end else begin
            w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
        end
    end

    // Shift register: capture on accept, shift on each consumed bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shreg <= '0;
        end else if (w_accept) begin
            r_shreg <= bus.data_in;
        end else if (w_in_shift && bus.shift_en) begin
            r_shreg <= w_shifted;
        end
    end

    // Done pulse: one cycle after the final bit is consumed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
        end
    end

    assign bus.load_ready = w_ready;
    assign bus.out_valid  = w_in_shift;
    assign bus.data_out   = w_in_shift & w_bit;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_piso_sr.sv
// Bench for piso_sr: bit-queue reference model, directed cases,
// random traffic and a serial loopback into a receive register.
module tb_piso_sr;
    import sr_pkg::*;

    localparam int W = SR_WIDTH;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         lv;
    logic         se;

    always #5 clk = ~clk;

    piso_sr_if #(.WIDTH(W)) bm ();
    piso_sr_if #(.WIDTH(W)) bl ();

    assign bm.data_in    = din;
    assign bm.load_valid = lv;
    assign bm.shift_en   = se;
    assign bl.data_in    = din;
    assign bl.load_valid = lv;
    assign bl.shift_en   = se;

    piso_sr #(.WIDTH(W), .MSB_FIRST(1'b1)) u_m (
        .clk   (clk),
        .reset (reset),
        .bus   (bm.slave)
    );

    piso_sr #(.WIDTH(W), .MSB_FIRST(1'b0)) u_l (
        .clk   (clk),
        .reset (reset),
        .bus   (bl.slave)
    );

    // Model: the bits still owed by each DUT, in emission order
    bit           qm[$];
    bit           ql[$];
    bit           dm_exp;
    bit           dl_exp;
    logic [W-1:0] sent[$];
    logic [W-1:0] rx;

    int           checks = 0;
    int           errors = 0;
    int           dcnt_m, dcnt_l, nlog_m, nlog_l, loops;
    logic [31:0]  log_m, log_l;
    logic         last_lr_m;
    logic         s_ov, s_lr, s_do, s_dn;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic bit exp_ready(input int n);
        return (n == 0) || (n == 1 && se);
    endfunction

    // Per-cycle comparison of both DUTs against the model
    task automatic check_cycle();
        bit ovm, ovl;
        ovm = (qm.size() != 0);
        ovl = (ql.size() != 0);
        chk("m_out_valid",  bm.out_valid,  ovm);
        chk("m_data_out",   bm.data_out,   ovm ? qm[0] : 1'b0);
        chk("m_load_ready", bm.load_ready, exp_ready(qm.size()));
        chk("m_done",       bm.done,       dm_exp);
        chk("l_out_valid",  bl.out_valid,  ovl);
        chk("l_data_out",   bl.data_out,   ovl ? ql[0] : 1'b0);
        chk("l_load_ready", bl.load_ready, exp_ready(ql.size()));
        chk("l_done",       bl.done,       dl_exp);
        last_lr_m = bm.load_ready;
        if (bm.done === 1'b1) begin
            dcnt_m++;
            if (sent.size() != 0) begin
                chk("loopback_word", rx, sent.pop_front());
                loops++;
            end
        end
        if (bl.done === 1'b1) dcnt_l++;
        if (bm.out_valid === 1'b1) begin
            log_m = {log_m[30:0], bm.data_out};
            nlog_m++;
            if (se) rx = {rx[W-2:0], bm.data_out};
        end
        if (bl.out_valid === 1'b1) begin
            log_l = {log_l[30:0], bl.data_out};
            nlog_l++;
        end
    endtask

    // Model update at a rising edge
    task automatic model_edge();
        bit lr, fm, fl;
        lr = exp_ready(qm.size());
        fm = 1'b0;
        fl = 1'b0;
        if (se && qm.size() != 0) begin
            void'(qm.pop_front());
            fm = (qm.size() == 0);
        end
        if (se && ql.size() != 0) begin
            void'(ql.pop_front());
            fl = (ql.size() == 0);
        end
        if (lr && lv) begin
            for (int i = 0; i < W; i++) begin
                qm.push_back(din[W-1-i]);
                ql.push_back(din[i]);
            end
            sent.push_back(din);
        end
        dm_exp = fm;
        dl_exp = fl;
    endtask

    task automatic cyc(input logic v, input logic [W-1:0] d,
                       input logic s);
        @(negedge clk);
        lv  = v;
        din = d;
        se  = s;
        #1;
        check_cycle();
        @(posedge clk);
        model_edge();
    endtask

    task automatic clr_logs();
        log_m  = '0;
        log_l  = '0;
        nlog_m = 0;
        nlog_l = 0;
        dcnt_m = 0;
        dcnt_l = 0;
    endtask

    // Reset asserted mid-cycle; outputs snapshotted 1 ns later
    task automatic do_reset(input logic v, input logic [W-1:0] d);
        @(negedge clk);
        #3;
        lv    = v;
        din   = d;
        reset = 1'b0;
        #1;
        qm.delete();
        ql.delete();
        sent.delete();
        dm_exp = 1'b0;
        dl_exp = 1'b0;
        s_ov = bm.out_valid;
        s_lr = bm.load_ready;
        s_do = bm.data_out;
        s_dn = bm.done;
        check_cycle();
        @(posedge clk);
        @(negedge clk);
        lv    = 1'b0;
        se    = 1'b0;
        reset = 1'b1;
        clr_logs();
    endtask

    initial begin
        reset = 1'b0;
        lv    = 1'b0;
        se    = 1'b0;
        din   = '0;
        rx    = '0;
        loops = 0;
        clr_logs();
        dm_exp = 1'b0;
        dl_exp = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // 1: mid-cycle reset while loaded and while offering a word
        cyc(1'b1, 4'hF, 1'b1);
        cyc(1'b0, 4'h0, 1'b0);
        do_reset(1'b1, 4'hF);
        chk("t1_out_valid",  s_ov, 1'b0);
        chk("t1_load_ready", s_lr, 1'b1);
        chk("t1_data_out",   s_do, 1'b0);
        chk("t1_done",       s_dn, 1'b0);
        cyc(1'b0, 4'h0, 1'b1);

        // 2: plain word, continuous shifting
        clr_logs();
        cyc(1'b1, 4'b1011, 1'b1);
        repeat (5) cyc(1'b0, 4'h0, 1'b1);
        chk("t2_bits",  log_m, 32'b1011);
        chk("t2_nbits", nlog_m, 4);
        chk("t2_done",  dcnt_m, 1);

        // 3: stall two cycles on the first bit
        clr_logs();
        cyc(1'b1, 4'b1011, 1'b1);
        cyc(1'b0, 4'h0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0);
        repeat (5) cyc(1'b0, 4'h0, 1'b1);
        chk("t3_bits",  log_m, 32'b111011);
        chk("t3_nbits", nlog_m, 6);
        chk("t3_done",  dcnt_m, 1);

        // 4: back-to-back words, reload on the last-bit cycle
        clr_logs();
        cyc(1'b1, 4'b1011, 1'b1);
        repeat (3) cyc(1'b0, 4'h0, 1'b1);
        cyc(1'b1, 4'b0110, 1'b1);
        repeat (5) cyc(1'b0, 4'h0, 1'b1);
        chk("t4_bits",  log_m, 32'b10110110);
        chk("t4_nbits", nlog_m, 8);
        chk("t4_done",  dcnt_m, 2);

        // 5: offer mid-word is refused
        clr_logs();
        cyc(1'b1, 4'b1000, 1'b1);
        repeat (2) cyc(1'b0, 4'h0, 1'b1);
        cyc(1'b1, 4'b1111, 1'b1);
        chk("t5_ready", last_lr_m, 1'b0);
        repeat (3) cyc(1'b0, 4'h0, 1'b1);
        chk("t5_bits",  log_m, 32'b1000);
        chk("t5_nbits", nlog_m, 4);
        chk("t5_done",  dcnt_m, 1);

        // 6: abort by reset, then LSB-first word
        cyc(1'b1, 4'b1011, 1'b1);
        repeat (2) cyc(1'b0, 4'h0, 1'b1);
        do_reset(1'b0, 4'h0);
        cyc(1'b0, 4'h0, 1'b1);
        chk("t6_no_done", dcnt_l, 0);
        cyc(1'b1, 4'b0001, 1'b1);
        repeat (5) cyc(1'b0, 4'h0, 1'b1);
        chk("t6_bits",  log_l, 32'b1000);
        chk("t6_nbits", nlog_l, 4);
        chk("t6_done",  dcnt_l, 1);

        // Random traffic with loopback into rx
        loops = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset(1'($urandom_range(0, 1)), W'($urandom));
            end else begin
                cyc(1'($urandom_range(0, 1)), W'($urandom),
                    ($urandom_range(0, 3) != 0));
            end
        end
        repeat (8) cyc(1'b0, 4'h0, 1'b1);
        chk("loopback_count_ge20", 32'(loops >= 20), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
